// File: rtl/recon_pkg.sv
// Shared types and default geometry for the reconstruction block scheduler.
package recon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        RUN     = 2'd2,
        WRITE   = 2'd3
    } sched_state_t;

    // 1920x1080 frame in 8x8 blocks
    localparam int unsigned FRAME_W_BLK = 240;
    localparam int unsigned FRAME_H_BLK = 135;

    localparam int unsigned COMB_LAT_DEFAULT = 2;
    localparam int unsigned RUN_CNT_W        = 3;

    // Coordinate width that stays legal for a single-block dimension
    function automatic int unsigned coord_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/recon_block_scheduler_if.sv
// Source, combiner and writer handshake bundle seen by the block scheduler.
interface recon_block_scheduler_if #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 8
);
    logic          pred_valid;
    logic          pred_ready;
    logic          res_valid;
    logic          res_ready;
    logic          comb_enable;
    logic          comb_done;
    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_blk_x;
    logic [YW-1:0] wr_blk_y;

    modport master (
        input  pred_valid, res_valid, comb_done, wr_ready,
        output pred_ready, res_ready, comb_enable, wr_valid, wr_blk_x, wr_blk_y
    );

    modport slave (
        output pred_valid, res_valid, comb_done, wr_ready,
        input  pred_ready, res_ready, comb_enable, wr_valid, wr_blk_x, wr_blk_y
    );
endinterface

// File: rtl/raster_block_counter.sv
// Raster-order block position counter; last flags the bottom-right block.
module raster_block_counter #(
    parameter int unsigned W  = 240,
    parameter int unsigned H  = 135,
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);
    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;

    always_comb begin
        x_n = x;
        y_n = y;
        if (clr) begin
            x_n = '0;
            y_n = '0;
        end else if (adv) begin
            if (x == X_MAX) begin
                x_n = '0;
                y_n = (y == Y_MAX) ? '0 : y + YW'(1);
            end else begin
                x_n = x + XW'(1);
            end
        end
    end

    // last is registered alongside the position it describes
    always_ff @(posedge clk) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            last <= (X_MAX == '0) && (Y_MAX == '0);
        end else begin
            x    <= x_n;
            y    <= y_n;
            last <= (x_n == X_MAX) && (y_n == Y_MAX);
        end
    end

endmodule

// File: rtl/recon_block_scheduler.sv
// Joins prediction and residual blocks, sequences the combiner enable and
// hands each reconstructed block to the frame-buffer writer in raster order.
module recon_block_scheduler
    import recon_pkg::*;
#(
    parameter int unsigned FRAME_W_BLK = recon_pkg::FRAME_W_BLK,
    parameter int unsigned FRAME_H_BLK = recon_pkg::FRAME_H_BLK,
    parameter int unsigned COMB_LAT    = COMB_LAT_DEFAULT,
    parameter int unsigned XW          = coord_width(FRAME_W_BLK),
    parameter int unsigned YW          = coord_width(FRAME_H_BLK)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    recon_block_scheduler_if.master bus,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_done
);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_WAIT_IN = WAIT_IN;
    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_WRITE   = WRITE;

    localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(COMB_LAT - 1);

    logic [1:0]           state, state_n;
    logic [RUN_CNT_W-1:0] run_cnt, run_cnt_n;
    logic                 first_wr, first_wr_n;
    logic                 enable_q, enable_n;
    logic                 last_run_q, last_run_n;
    logic                 wr_valid_q, wr_valid_n;
    logic                 busy_n, frame_done_n, err_done_n;
    logic                 cnt_clr, cnt_adv, cnt_last;
    logic [XW-1:0]        blk_x;
    logic [YW-1:0]        blk_y;

    raster_block_counter #(
        .W  (FRAME_W_BLK),
        .H  (FRAME_H_BLK),
        .XW (XW),
        .YW (YW)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .adv   (cnt_adv),
        .x     (blk_x),
        .y     (blk_y),
        .last  (cnt_last)
    );

    // Next state, position control and next values of the registered outputs
    always_comb begin
        state_n      = state;
        run_cnt_n    = run_cnt;
        first_wr_n   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_adv      = 1'b0;
        frame_done_n = 1'b0;
        err_done_n   = err_done;

        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n    = S_WAIT_IN;
                        cnt_clr    = 1'b1;
                        err_done_n = 1'b0;
                    end
                end
                S_WAIT_IN: begin
                    if (bus.pred_valid && bus.res_valid) begin
                        state_n   = S_RUN;
                        run_cnt_n = '0;
                    end
                end
                S_RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state_n    = S_WRITE;
                        first_wr_n = 1'b1;
                    end else begin
                        run_cnt_n = run_cnt + RUN_CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (first_wr && !bus.comb_done) begin
                        err_done_n = 1'b1;
                    end
                    if (bus.wr_ready) begin
                        cnt_adv = 1'b1;
                        if (cnt_last) begin
                            state_n      = S_IDLE;
                            frame_done_n = 1'b1;
                        end else begin
                            state_n = S_WAIT_IN;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        enable_n   = (state_n == S_RUN);
        last_run_n = (state_n == S_RUN) && (run_cnt_n == RUN_LAST);
        wr_valid_n = (state_n == S_WRITE);
        busy_n     = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            run_cnt    <= '0;
            first_wr   <= 1'b0;
            enable_q   <= 1'b0;
            last_run_q <= 1'b0;
            wr_valid_q <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_done   <= 1'b0;
        end else begin
            state      <= state_n;
            run_cnt    <= run_cnt_n;
            first_wr   <= first_wr_n;
            enable_q   <= enable_n;
            last_run_q <= last_run_n;
            wr_valid_q <= wr_valid_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            err_done   <= err_done_n;
        end
    end

    // Readies must drop in the same cycle as abort or reset so no handshake completes
    assign bus.pred_ready  = last_run_q && !abort && !reset;
    assign bus.res_ready   = last_run_q && !abort && !reset;
    assign bus.comb_enable = enable_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_blk_x    = blk_x;
    assign bus.wr_blk_y    = blk_y;

endmodule

// File: doc/recon_block_scheduler.md
# recon_block_scheduler

Sequencing controller for the reconstruction block combiner in the camera decoder. It joins one prediction block and one residual block from two independent valid/ready sources, then drives the combiner's `enable` for the cycles the combiner's two-stage register path needs. It checks the combiner's `done`, presents the reconstructed block to the frame-buffer writer with its raster block coordinates, and reports frame completion.

## Interface
Parameters:
- `FRAME_W_BLK`, default 240: blocks per row (1920/8).
- `FRAME_H_BLK`, default 135: block rows per frame (1080/8).
- `COMB_LAT`, default 2: cycles `comb_enable` is held per block. The combiner registers P/R and sums the previously registered values, so 2 is required. Legal range 1..7.
- `XW`, default `$clog2(FRAME_W_BLK)`: x coordinate width.
- `YW`, default `$clog2(FRAME_H_BLK)`: y coordinate width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  frame start pulse; honoured only in IDLE.
- `abort`  in  1  synchronous abort; returns the block to IDLE.
- `pred_valid`  in  1  prediction block available; data held by source.
- `pred_ready`  out  1  prediction block consumed.
- `res_valid`  in  1  residual block available; data held by source.
- `res_ready`  out  1  residual block consumed.
- `comb_enable`  out  1  to combiner `enable`.
- `comb_done`  in  1  from combiner `done`.
- `wr_valid`  out  1  reconstructed block valid toward frame-buffer writer.
- `wr_ready`  in  1  writer accepts.
- `wr_blk_x`  out  XW  block column of current block.
- `wr_blk_y`  out  YW  block row of current block.
- `busy`  out  1  state != IDLE.
- `frame_done`  out  1  one-cycle pulse after the last block is written.
- `err_done`  out  1  sticky; `comb_done` was missing when expected. Cleared by `reset` or `start`.

## Operation
- **States:** IDLE, WAIT_IN, RUN, WRITE.
- **IDLE:**
  - `start` clears x=y=0 and `err_done`, then goes to WAIT_IN.
  - `start` outside IDLE is ignored.
- **WAIT_IN:**
  - Join: transition to RUN only in a cycle where `pred_valid` && `res_valid`.
  - A single valid waits indefinitely with no consumption.
- **RUN:**
  - `comb_enable`=1 for exactly COMB_LAT cycles, tracked by a run counter.
  - `pred_ready`=`res_ready`=1 only in the last RUN cycle, so both handshakes complete together and source data stays stable for all enable cycles.
  - Then go to WRITE.
- **WRITE:**
  - `wr_valid`=1; `comb_enable`=0, so the combiner holds Recon.
  - On `wr_valid` && `wr_ready`, advance the raster position: x+1; at x=FRAME_W_BLK-1, x wraps to 0 and y+1.
  - If the block was (FRAME_W_BLK-1, FRAME_H_BLK-1): pulse `frame_done`, go to IDLE.
  - Otherwise go to WAIT_IN.
- **Done check:** in the first WRITE cycle, `comb_done` must be 1. If it is 0, set `err_done`; the flow still continues.
- **Abort:** `abort` in any state forces IDLE next cycle.
  - No ready pulses, no `frame_done`, counters frozen.
  - If abort coincides with the last RUN cycle, abort wins and `pred_ready`/`res_ready` are forced 0.
- **Coordinates:** `wr_blk_x`/`wr_blk_y` are stable for the whole WRITE state. Unsigned arithmetic; no overflow beyond the wrap points.

## Timing
- Reset values: state IDLE; x=y=0; run counter 0; all outputs 0.
- Reset mid-block: the block is lost and no handshake completes. The source re-presents it after software restarts the frame.
- Both valids seen in cycle t:
  - RUN occupies t+1..t+COMB_LAT.
  - ready pulses at t+COMB_LAT.
  - `wr_valid` rises at t+COMB_LAT+1.
- Throughput: minimum per-block period is COMB_LAT+2 cycles, i.e. 4 with `wr_ready` tied high.
- `frame_done` is asserted in the cycle after the final write handshake, coincident with the first IDLE cycle.
- `start` in the same cycle as `frame_done` (already IDLE) is honoured.

## Structure
- Package `recon_pkg`:
  - `sched_state_t` enum {IDLE, WAIT_IN, RUN, WRITE}.
  - Default frame geometry constants (FRAME_W_BLK, FRAME_H_BLK).
  - `COMB_LAT_DEFAULT`=2.
- Sub-module `raster_block_counter`:
  - Parameterised x/y counter with `clr` and `adv` inputs.
  - `last` output, true at (W-1, H-1).
- Top: FSM, run counter, `err_done` flag.

## Test plan
- Reset then `start`, both valids high, `wr_ready`=1, FRAME 4×2:
  - 8 blocks at 4-cycle period.
  - Coordinates (0,0)..(3,1) in raster order.
  - `frame_done` once, 1 cycle after the 8th write.
- `pred_valid` high, `res_valid` low for 10 cycles, then high:
  - No ready and no `comb_enable` during the wait.
  - Enable high exactly 2 cycles after the join.
  - Both readies pulse together once.
- `wr_ready` low for 5 cycles in WRITE:
  - `wr_valid` held.
  - Coordinates stable.
  - `comb_enable`=0 throughout.
  - Advance only on the handshake.
- Combiner model withholds `done` on block 3:
  - `err_done` set and stays set.
  - Frame still completes.
  - Next `start` clears `err_done`.
- `abort` on the last RUN cycle of block (2,0):
  - Readies stay 0.
  - IDLE next cycle, no `frame_done`.
  - Reset mid-WRITE gives all outputs 0 the following cycle.
- COMB_LAT=1, FRAME 1×1:
  - Enable 1 cycle.
  - `wr_valid` 2 cycles after join.
  - `frame_done` after a single write.
